// File: rtl/trace_input_fifo.sv
// Trace input FIFO: circular queue of N-lane vectors with per-entry EOF,
// a registered output stage with valid/ready, occupancy/full/empty status,
// a saturating drop counter and a runtime-configured chain id.
module trace_input_fifo #(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IB_DEPTH   = 4,
  parameter int unsigned CFG_ID     = 0,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enqueue,
  input  logic                                eof_in,
  input  logic                                tracing,
  input  logic [7:0]                          configId,
  input  logic [7:0]                          configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]        vector_in,
  input  logic                                ready_in,
  output logic                                valid_out,
  output logic                                eof_out,
  output logic [N-1:0][DATA_WIDTH-1:0]        vector_out,
  output logic                                chainId_out,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(IB_DEPTH):0]           occupancy,
  output logic [DROP_W-1:0]                   drop_count
);

  // Storage excludes the output register, so it holds one entry fewer than the total capacity.
  localparam int unsigned SD    = IB_DEPTH - 1;
  localparam int unsigned PTR_W = (SD > 1) ? $clog2(SD) : 1;
  localparam int unsigned OCC_W = $clog2(IB_DEPTH) + 1;

  typedef struct packed {
    logic                         eof;
    logic [N-1:0][DATA_WIDTH-1:0] vec;
  } entry_t;

  entry_t           mem [SD];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic             pop;
  logic             accept;
  logic             drop;
  logic             stage_free;
  logic [OCC_W-1:0] st_cnt;
  logic             st_empty;
  logic             load_st;
  logic             bypass;
  logic             write_st;
  logic             cfg_hit;
  logic             unused_cfg;

  // Handshake and routing decisions for this cycle.
  always_comb begin
    pop        = valid_out & ready_in;
    accept     = enqueue & tracing & (~full | pop);
    drop       = enqueue & tracing & full & ~pop;
    stage_free = ~valid_out | pop;
    // The output stage is always loaded before storage holds anything, so storage count
    // is the occupancy less the output register.
    st_cnt     = occupancy - OCC_W'(valid_out);
    st_empty   = (st_cnt == '0);
    load_st    = stage_free & ~st_empty;
    bypass     = stage_free & st_empty & accept;
    write_st   = accept & ~bypass;
    cfg_hit    = (configId == 8'(CFG_ID));
    full       = (occupancy == OCC_W'(IB_DEPTH));
    empty      = (occupancy == '0);
    unused_cfg = ^configData[7:2];
  end

  // Storage array write; contents need no reset.
  always_ff @(posedge clk) begin
    if (write_st) begin
      mem[wr_ptr] <= entry_t'{eof: eof_in, vec: vector_in};
    end
  end

  // Write/read pointers wrapping at the end of storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (write_st) begin
        wr_ptr <= (wr_ptr == PTR_W'(SD - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (load_st) begin
        rd_ptr <= (rd_ptr == PTR_W'(SD - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // Output register: refill from storage head, else bypass the input, else go idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out  <= 1'b0;
      eof_out    <= 1'b0;
      vector_out <= '0;
    end else if (stage_free) begin
      if (load_st) begin
        valid_out  <= 1'b1;
        eof_out    <= mem[rd_ptr].eof;
        vector_out <= mem[rd_ptr].vec;
      end else if (accept) begin
        valid_out  <= 1'b1;
        eof_out    <= eof_in;
        vector_out <= vector_in;
      end else begin
        valid_out  <= 1'b0;
      end
    end
  end

  // Occupancy including the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(accept) - OCC_W'(pop);
    end
  end

  // Saturating drop counter; a config clear beats a same-cycle drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (cfg_hit && configData[1]) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + DROP_W'(1);
    end
  end

  // Chain id register written through the config port.
  always_ff @(posedge clk) begin
    if (reset) begin
      chainId_out <= 1'b0;
    end else if (cfg_hit) begin
      chainId_out <= configData[0];
    end
  end

endmodule

// File: tb/tb_trace_input_fifo.sv
// Directed self-checking bench for trace_input_fifo (default parameters).
module tb_trace_input_fifo;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned D  = 4;

  logic                 clk;
  logic                 reset;
  logic                 enqueue;
  logic                 eof_in;
  logic                 tracing;
  logic [7:0]           configId;
  logic [7:0]           configData;
  logic [N-1:0][DW-1:0] vector_in;
  logic                 ready_in;
  logic                 valid_out;
  logic                 eof_out;
  logic [N-1:0][DW-1:0] vector_out;
  logic                 chainId_out;
  logic                 full;
  logic                 empty;
  logic [2:0]           occupancy;
  logic [15:0]          drop_count;

  int checks;
  int errors;

  trace_input_fifo #(.N(N), .DATA_WIDTH(DW), .IB_DEPTH(D), .CFG_ID(0), .DROP_W(16)) dut (
    .clk(clk), .reset(reset), .enqueue(enqueue), .eof_in(eof_in), .tracing(tracing),
    .configId(configId), .configData(configData), .vector_in(vector_in), .ready_in(ready_in),
    .valid_out(valid_out), .eof_out(eof_out), .vector_out(vector_out),
    .chainId_out(chainId_out), .full(full), .empty(empty), .occupancy(occupancy),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane 0 carries v; other lanes carry v plus the lane index in the upper half.
  function automatic logic [N-1:0][DW-1:0] mkvec(input int v);
    logic [N-1:0][DW-1:0] r;
    for (int i = 0; i < N; i++) r[i] = DW'(v) + (DW'(i) << 16);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enqueue = 1'b0; eof_in = 1'b0; tracing = 1'b1;
    configId = 8'hFF; configData = 8'h00; vector_in = '0; ready_in = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", valid_out); end
    checks++; if (eof_out !== 1'b0) begin errors++; $display("FAIL reset_eof got %0b exp 0", eof_out); end
    checks++; if (vector_out !== '0) begin errors++; $display("FAIL reset_vector got %h exp 0", vector_out); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got e%0b f%0b exp e1 f0", empty, full); end
    checks++; if (drop_count !== 16'd0 || chainId_out !== 1'b0) begin errors++; $display("FAIL reset_cnt got d%0d c%0b exp d0 c0", drop_count, chainId_out); end
  endtask

  task automatic test_in_order();
    ready_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      enqueue = 1'b1; vector_in = mkvec(i);
      if (i == 1) begin
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL no_passthrough got %0b exp 0", valid_out); end
      end
      step();
      checks++; if (valid_out !== 1'b1 || vector_out !== mkvec(i)) begin errors++; $display("FAIL order1_%0d got v%0b lane0 %0d exp v1 lane0 %0d", i, valid_out, vector_out[0], i); end
      checks++; if (occupancy !== 3'd1) begin errors++; $display("FAIL order1_occ_%0d got %0d exp 1", i, occupancy); end
    end
    enqueue = 1'b0;
    step();
    checks++; if (valid_out !== 1'b0 || occupancy !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL order1_drain got v%0b occ %0d e%0b exp v0 occ 0 e1", valid_out, occupancy, empty); end
  endtask

  task automatic test_fill_drop();
    ready_in = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      enqueue = 1'b1; vector_in = mkvec(10 + i);
      step();
      checks++; if (occupancy !== 3'((i < 4) ? i : 4)) begin errors++; $display("FAIL fill_occ_%0d got %0d exp %0d", i, occupancy, (i < 4) ? i : 4); end
    end
    enqueue = 1'b0;
    checks++; if (full !== 1'b1 || drop_count !== 16'd2) begin errors++; $display("FAIL fill_drop got f%0b d%0d exp f1 d2", full, drop_count); end
    ready_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (valid_out !== 1'b1 || vector_out !== mkvec(11 + k)) begin errors++; $display("FAIL fill_out_%0d got v%0b lane0 %0d exp v1 lane0 %0d", k, valid_out, vector_out[0], 11 + k); end
      step();
    end
    checks++; if (valid_out !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL fill_end got v%0b occ %0d exp v0 occ 0", valid_out, occupancy); end
  endtask

  task automatic test_back_to_back();
    ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enqueue = 1'b1; vector_in = mkvec(21 + i);
      step();
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL b2b_full got %0b exp 1", full); end
    ready_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      enqueue = 1'b1; vector_in = mkvec(25 + k);
      checks++; if (vector_out !== mkvec(21 + k) || occupancy !== 3'd4) begin errors++; $display("FAIL b2b_%0d got lane0 %0d occ %0d exp lane0 %0d occ 4", k, vector_out[0], occupancy, 21 + k); end
      step();
    end
    enqueue = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (valid_out !== 1'b1 || vector_out !== mkvec(31 + k)) begin errors++; $display("FAIL b2b_drain_%0d got v%0b lane0 %0d exp v1 lane0 %0d", k, valid_out, vector_out[0], 31 + k); end
      step();
    end
    checks++; if (valid_out !== 1'b0 || drop_count !== 16'd2) begin errors++; $display("FAIL b2b_end got v%0b d%0d exp v0 d2", valid_out, drop_count); end
  endtask

  task automatic test_eof();
    logic [15:0] pat;
    int idx;
    pat = 16'b1111_1111_1011_0010;
    idx = 0;
    for (int c = 0; c < 30 && idx < 5; c++) begin
      enqueue   = (c < 5);
      eof_in    = (c == 2);
      vector_in = mkvec(41 + c);
      ready_in  = pat[c % 16];
      if (valid_out) begin
        checks++; if (vector_out !== mkvec(41 + idx) || eof_out !== (idx == 2)) begin errors++; $display("FAIL eof_%0d got lane0 %0d eof %0b exp lane0 %0d eof %0b", idx, vector_out[0], eof_out, 41 + idx, idx == 2); end
        if (ready_in) idx++;
      end
      step();
    end
    enqueue = 1'b0; eof_in = 1'b0; ready_in = 1'b0;
    checks++; if (idx != 5) begin errors++; $display("FAIL eof_timeout got %0d exp 5", idx); end
    step();
    checks++; if (valid_out !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL eof_end got v%0b occ %0d exp v0 occ 0", valid_out, occupancy); end
  endtask

  task automatic test_tracing_off();
    ready_in = 1'b0; tracing = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enqueue = 1'b1; vector_in = mkvec(90 + i);
      step();
    end
    checks++; if (occupancy !== 3'd0 || valid_out !== 1'b0 || drop_count !== 16'd2) begin errors++; $display("FAIL trace_off_empty got occ %0d v%0b d%0d exp occ 0 v0 d2", occupancy, valid_out, drop_count); end
    tracing = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vector_in = mkvec(51 + i);
      step();
    end
    tracing = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++; if (occupancy !== 3'd4 || drop_count !== 16'd2) begin errors++; $display("FAIL trace_off_full got occ %0d d%0d exp occ 4 d2", occupancy, drop_count); end
    tracing = 1'b1; enqueue = 1'b0;
  endtask

  task automatic test_config_reset();
    enqueue = 1'b1; vector_in = mkvec(99); ready_in = 1'b0;
    configId = 8'h00; configData = 8'h03;
    step();
    checks++; if (chainId_out !== 1'b1 || drop_count !== 16'd0) begin errors++; $display("FAIL cfg_clear got c%0b d%0d exp c1 d0", chainId_out, drop_count); end
    configId = 8'h05; configData = 8'h00;
    step();
    checks++; if (chainId_out !== 1'b1 || drop_count !== 16'd1) begin errors++; $display("FAIL cfg_other got c%0b d%0d exp c1 d1", chainId_out, drop_count); end
    configId = 8'h00; enqueue = 1'b0;
    step();
    configId = 8'hFF;
    checks++; if (chainId_out !== 1'b0 || drop_count !== 16'd1) begin errors++; $display("FAIL cfg_zero got c%0b d%0d exp c0 d1", chainId_out, drop_count); end
    ready_in = 1'b1;
    step();
    ready_in = 1'b0;
    checks++; if (occupancy !== 3'd3 || vector_out !== mkvec(52)) begin errors++; $display("FAIL pre_reset got occ %0d lane0 %0d exp occ 3 lane0 52", occupancy, vector_out[0]); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (empty !== 1'b1 || valid_out !== 1'b0 || occupancy !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL mid_reset got e%0b v%0b occ %0d f%0b exp e1 v0 occ 0 f0", empty, valid_out, occupancy, full); end
    step();
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL post_reset got v%0b exp v0", valid_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_in_order();
    test_fill_drop();
    test_back_to_back();
    test_eof();
    test_tracing_off();
    test_config_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
